// File: rtl/alu_pkg.sv
// -----------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the multiply issue block:
//   - mul_state_e : issue FSM state encoding
//   - INT_MIN     : the one two's-complement value with no positive magnitude
//   - tc_to_sm    : two's complement -> sign-magnitude (bit 31 sign, 30:0 |x|)
//   - sm_to_tc    : sign-magnitude -> two's complement
// -----------------------------------------------------------------------------
package alu_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LAUNCH = 2'd1,
        ST_WAIT   = 2'd2,
        ST_RESP   = 2'd3
    } mul_state_e;

    localparam logic [31:0] INT_MIN = 32'h8000_0000;

    // Low 31 bits of |x| are the low 31 bits of the negation, so the
    // negation is done directly at 31 bits. INT_MIN maps to "negative zero";
    // the issue logic handles that operand on its fast path instead.
    function automatic logic [31:0] tc_to_sm(input logic [31:0] x);
        logic [30:0] mag;
        mag = x[31] ? (~x[30:0] + 31'd1) : x[30:0];
        return {x[31], mag};
    endfunction

    function automatic logic [31:0] sm_to_tc(input logic [31:0] r);
        logic [31:0] mag;
        mag = {1'b0, r[30:0]};
        return r[31] ? (~mag + 32'd1) : mag;
    endfunction

endpackage

// File: rtl/sm_conv.sv
// -----------------------------------------------------------------------------
// sm_conv
// Combinational number-format converter between two's complement and
// sign-magnitude. TO_SM selects the direction.
// Ports:
//   din  [31:0] : value in the source format
//   dout [31:0] : value in the destination format
// -----------------------------------------------------------------------------
module sm_conv
    import alu_pkg::*;
#(
    parameter bit TO_SM = 1'b1
) (
    input  logic [31:0] din,
    output logic [31:0] dout
);

    generate
        if (TO_SM) begin : g_to_sm
            assign dout = tc_to_sm(din);
        end else begin : g_to_tc
            assign dout = sm_to_tc(din);
        end
    endgenerate

endmodule

// File: rtl/mul_issue.sv
// -----------------------------------------------------------------------------
// mul_issue
// Issues one signed 32-bit multiply at a time to an external sign-magnitude
// multiplier and returns the two's-complement product on a valid/ready
// writeback handshake. Zero and INT_MIN operands are resolved locally without
// launching the multiplier. A WAIT-cycle watchdog turns a lost multiplier
// completion into an error response. All outputs are registered.
// Ports:
//   i_clk, i_rst                    : clock, async active-high reset
//   i_req_valid, o_req_ready        : request handshake (ready only in IDLE)
//   i_op_a, i_op_b, i_rd            : two's-complement operands, dest tag
//   o_mul_valid, o_mul_a, o_mul_b   : launch pulse + sign-magnitude operands
//   i_mul_valid, i_mul_result       : multiplier completion + SM product
//   o_rsp_valid, i_rsp_ready        : writeback handshake
//   o_rsp_data, o_rsp_rd, o_rsp_err : product (two's complement), tag, error
//   o_busy                          : high whenever not IDLE
// -----------------------------------------------------------------------------
module mul_issue
    import alu_pkg::*;
#(
    parameter int MUL_TIMEOUT = 63
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [31:0] i_op_a,
    input  logic [31:0] i_op_b,
    input  logic [4:0]  i_rd,
    output logic        o_mul_valid,
    output logic [31:0] o_mul_a,
    output logic [31:0] o_mul_b,
    input  logic        i_mul_valid,
    input  logic [31:0] i_mul_result,
    output logic        o_rsp_valid,
    input  logic        i_rsp_ready,
    output logic [31:0] o_rsp_data,
    output logic [4:0]  o_rsp_rd,
    output logic        o_rsp_err,
    output logic        o_busy
);

    localparam int                CNT_W    = $clog2(MUL_TIMEOUT + 1);
    // Value of the counter during the last permitted WAIT cycle.
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MUL_TIMEOUT - 1);

    mul_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic [31:0] op_a_sm, op_b_sm, result_tc;
    logic [31:0] mul_a_d, mul_b_d, rsp_data_d;
    logic [4:0]  rsp_rd_d;
    logic        rsp_err_d;

    logic accept;
    logic fast_zero, fast_min, min_other_odd;

    sm_conv #(.TO_SM(1'b1)) u_conv_a   (.din(i_op_a),       .dout(op_a_sm));
    sm_conv #(.TO_SM(1'b1)) u_conv_b   (.din(i_op_b),       .dout(op_b_sm));
    sm_conv #(.TO_SM(1'b0)) u_conv_res (.din(i_mul_result), .dout(result_tc));

    // o_req_ready is a registered decode of IDLE, so acceptance never depends
    // combinationally on the writeback side.
    assign accept = o_req_ready & i_req_valid;

    // INT_MIN has no 31-bit magnitude; its product is 2^31 * other, which
    // wraps to INT_MIN for an odd multiplier and to 0 for an even one.
    assign fast_zero     = (i_op_a == '0) || (i_op_b == '0);
    assign fast_min      = (i_op_a == INT_MIN) || (i_op_b == INT_MIN);
    assign min_other_odd = (i_op_a == INT_MIN) ? i_op_b[0] : i_op_a[0];

    always_comb begin
        // NOTE: every value written here gets a default first; a path that
        // leaves one unassigned would infer a latch.
        state_d    = state_q;
        cnt_d      = cnt_q;
        mul_a_d    = o_mul_a;
        mul_b_d    = o_mul_b;
        rsp_data_d = o_rsp_data;
        rsp_rd_d   = o_rsp_rd;
        rsp_err_d  = o_rsp_err;

        unique case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    rsp_rd_d  = i_rd;
                    rsp_err_d = 1'b0;
                    if (fast_zero) begin
                        state_d    = ST_RESP;
                        rsp_data_d = '0;
                    end else if (fast_min) begin
                        state_d    = ST_RESP;
                        rsp_data_d = min_other_odd ? INT_MIN : '0;
                    end else begin
                        // The operand registers also carry the operand signs.
                        state_d = ST_LAUNCH;
                        mul_a_d = op_a_sm;
                        mul_b_d = op_b_sm;
                    end
                end
            end

            ST_LAUNCH: begin
                state_d = ST_WAIT;
                cnt_d   = '0;
            end

            ST_WAIT: begin
                // Completion wins over the timeout in the final WAIT cycle.
                if (i_mul_valid) begin
                    state_d    = ST_RESP;
                    rsp_data_d = result_tc;
                    rsp_err_d  = 1'b0;
                    cnt_d      = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d    = ST_RESP;
                    rsp_data_d = '0;
                    rsp_err_d  = 1'b1;
                    cnt_d      = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end

            ST_RESP: begin
                if (i_rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end

            default: state_d = ST_IDLE;
        endcase
    end

    // Status outputs are decoded from the next state so they are registered
    // yet line up with the state they describe.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            o_req_ready <= 1'b1;
            o_mul_valid <= 1'b0;
            o_mul_a     <= '0;
            o_mul_b     <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_rd    <= '0;
            o_rsp_err   <= 1'b0;
            o_busy      <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            o_req_ready <= (state_d == ST_IDLE);
            o_mul_valid <= (state_d == ST_LAUNCH);
            o_mul_a     <= mul_a_d;
            o_mul_b     <= mul_b_d;
            o_rsp_valid <= (state_d == ST_RESP);
            o_rsp_data  <= rsp_data_d;
            o_rsp_rd    <= rsp_rd_d;
            o_rsp_err   <= rsp_err_d;
            o_busy      <= (state_d != ST_IDLE);
        end
    end

endmodule

// File: tb/tb_mul_issue.sv
// -----------------------------------------------------------------------------
// tb_mul_issue
// Directed bench for mul_issue: reset values, normal multiplies through a
// behavioural sign-magnitude multiplier, zero/INT_MIN fast paths, timeout and
// its boundary, writeback backpressure, and reset during WAIT.
// Inputs are driven and outputs sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_mul_issue;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_req_valid = 1'b0;
    logic        o_req_ready;
    logic [31:0] i_op_a = '0;
    logic [31:0] i_op_b = '0;
    logic [4:0]  i_rd = '0;
    logic        o_mul_valid;
    logic [31:0] o_mul_a;
    logic [31:0] o_mul_b;
    logic        i_mul_valid = 1'b0;
    logic [31:0] i_mul_result = '0;
    logic        o_rsp_valid;
    logic        i_rsp_ready = 1'b0;
    logic [31:0] o_rsp_data;
    logic [4:0]  o_rsp_rd;
    logic        o_rsp_err;
    logic        o_busy;

    int n_checks = 0;
    int n_fail   = 0;
    int mul_pulses = 0;
    bit mul_en  = 1'b1;
    int mul_lat = 1;

    mul_issue #(.MUL_TIMEOUT(63)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_req_valid  (i_req_valid),
        .o_req_ready  (o_req_ready),
        .i_op_a       (i_op_a),
        .i_op_b       (i_op_b),
        .i_rd         (i_rd),
        .o_mul_valid  (o_mul_valid),
        .o_mul_a      (o_mul_a),
        .o_mul_b      (o_mul_b),
        .i_mul_valid  (i_mul_valid),
        .i_mul_result (i_mul_result),
        .o_rsp_valid  (o_rsp_valid),
        .i_rsp_ready  (i_rsp_ready),
        .o_rsp_data   (o_rsp_data),
        .o_rsp_rd     (o_rsp_rd),
        .o_rsp_err    (o_rsp_err),
        .o_busy       (o_busy)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Launch pulse counter.
    always @(negedge i_clk) begin
        if (o_mul_valid) mul_pulses++;
    end

    // Behavioural multiplier: samples the launch, answers mul_lat falling
    // edges later with a one-cycle completion carrying the SM product
    // truncated to a 31-bit magnitude.
    always begin : mul_model
        logic [31:0] ma, mb;
        logic [61:0] prod;
        @(negedge i_clk);
        if (o_mul_valid && mul_en) begin
            ma = o_mul_a;
            mb = o_mul_b;
            repeat (mul_lat) @(negedge i_clk);
            if (o_busy && !o_rsp_valid)
                check("mul_operands_held", {o_mul_a, o_mul_b}, {ma, mb});
            prod         = 62'(ma[30:0]) * 62'(mb[30:0]);
            i_mul_result = {ma[31] ^ mb[31], prod[30:0]};
            i_mul_valid  = 1'b1;
            @(negedge i_clk);
            i_mul_valid  = 1'b0;
        end
    end

    // Presents one request at a falling edge; returns at the falling edge
    // after the accepting rising edge.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        i_req_valid = 1'b1;
        i_op_a      = a;
        i_op_b      = b;
        i_rd        = rd;
        @(posedge i_clk);
        #1;
        i_req_valid = 1'b0;
        @(negedge i_clk);
    endtask

    task automatic wait_rsp(input int max_cyc, output int cyc);
        cyc = 0;
        while (!o_rsp_valid && cyc < max_cyc) begin
            @(negedge i_clk);
            cyc++;
        end
        check("rsp_arrived", 64'(o_rsp_valid), 64'd1);
    endtask

    task automatic release_rsp();
        i_rsp_ready = 1'b1;
        @(negedge i_clk);
        i_rsp_ready = 1'b0;
        check("back_to_idle", {o_rsp_valid, o_req_ready, o_busy}, 3'b010);
    endtask

    task automatic check_reset_outs(input string tag);
        check({tag, "_ctl"},  {o_req_ready, o_mul_valid, o_rsp_valid, o_rsp_err, o_busy, o_rsp_rd},
                              {1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0});
        check({tag, "_mul"},  {o_mul_a, o_mul_b}, 64'd0);
        check({tag, "_data"}, 64'(o_rsp_data), 64'd0);
    endtask

    typedef struct {
        logic [31:0] a, b, sm_a, sm_b, exp;
        int          lat;
        logic [4:0]  rd;
    } norm_vec_t;

    typedef struct {
        logic [31:0] a, b, exp;
        logic [4:0]  rd;
    } fast_vec_t;

    norm_vec_t nv[5];
    fast_vec_t fv[6];

    initial begin
        int cyc, p0, wcnt, guard;

        nv[0] = '{32'h0000_0007, 32'hFFFF_FFFA, 32'h0000_0007, 32'h8000_0006, 32'hFFFF_FFD6, 3,  5'd5};
        nv[1] = '{32'hFFFF_FFFD, 32'hFFFF_FFFB, 32'h8000_0003, 32'h8000_0005, 32'h0000_000F, 1,  5'd1};
        nv[2] = '{32'h0000_03E8, 32'hFFFF_FC18, 32'h0000_03E8, 32'h8000_03E8, 32'hFFF0_BDC0, 5,  5'd31};
        nv[3] = '{32'h0001_0001, 32'h0001_0000, 32'h0001_0001, 32'h0001_0000, 32'h0001_0000, 2,  5'd17};
        nv[4] = '{32'h0000_0002, 32'h0000_0003, 32'h0000_0002, 32'h0000_0003, 32'h0000_0006, 63, 5'd3};

        fv[0] = '{32'h0000_0000, 32'h0000_3039, 32'h0000_0000, 5'd2};
        fv[1] = '{32'hFFFF_FFF7, 32'h0000_0000, 32'h0000_0000, 5'd4};
        fv[2] = '{32'h8000_0000, 32'h0000_0003, 32'h8000_0000, 5'd6};
        fv[3] = '{32'h8000_0000, 32'h0000_0004, 32'h0000_0000, 5'd8};
        fv[4] = '{32'h0000_0005, 32'h8000_0000, 32'h8000_0000, 5'd10};
        fv[5] = '{32'h8000_0000, 32'h8000_0000, 32'h0000_0000, 5'd12};

        // Reset values while reset is held.
        repeat (2) @(negedge i_clk);
        check_reset_outs("reset");
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);

        // Normal path through the multiplier.
        for (int i = 0; i < 5; i++) begin
            mul_en  = 1'b1;
            mul_lat = nv[i].lat;
            p0 = mul_pulses;
            send(nv[i].a, nv[i].b, nv[i].rd);
            check($sformatf("launch_%0d", i), {o_mul_valid, o_busy, o_req_ready}, 3'b110);
            check($sformatf("mul_ops_%0d", i), {o_mul_a, o_mul_b}, {nv[i].sm_a, nv[i].sm_b});
            wait_rsp(200, cyc);
            check($sformatf("latency_%0d", i), 64'(cyc), 64'(nv[i].lat + 1));
            check($sformatf("data_%0d", i), 64'(o_rsp_data), 64'(nv[i].exp));
            check($sformatf("err_rd_%0d", i), {o_rsp_err, o_rsp_rd}, {1'b0, nv[i].rd});
            release_rsp();
            repeat (2) @(negedge i_clk);
            #1;
            check($sformatf("one_pulse_%0d", i), 64'(mul_pulses - p0), 64'd1);
        end

        // Fast paths: response one cycle after acceptance, no launch.
        for (int i = 0; i < 6; i++) begin
            p0 = mul_pulses;
            send(fv[i].a, fv[i].b, fv[i].rd);
            check($sformatf("fast_ctl_%0d", i), {o_rsp_valid, o_mul_valid, o_busy, o_rsp_err}, 4'b1010);
            check($sformatf("fast_data_%0d", i), {o_rsp_rd, o_rsp_data}, {fv[i].rd, fv[i].exp});
            release_rsp();
            @(negedge i_clk);
            #1;
            check($sformatf("fast_no_pulse_%0d", i), 64'(mul_pulses - p0), 64'd0);
        end

        // Timeout: multiplier silent, then multiplier one cycle too late.
        for (int t = 0; t < 2; t++) begin
            mul_en  = (t == 1);
            mul_lat = 64;
            send(32'd2, 32'd3, 5'd7);
            wcnt  = 0;
            guard = 0;
            while (!o_rsp_valid && guard < 300) begin
                @(negedge i_clk);
                guard++;
                if (!o_rsp_valid && o_busy && !o_mul_valid) wcnt++;
            end
            check($sformatf("to_wait_cycles_%0d", t), 64'(wcnt), 64'd63);
            check($sformatf("to_rsp_%0d", t), {o_rsp_valid, o_rsp_err, o_rsp_rd}, {1'b1, 1'b1, 5'd7});
            check($sformatf("to_data_%0d", t), 64'(o_rsp_data), 64'd0);
            release_rsp();
            repeat (3) @(negedge i_clk);
            check($sformatf("to_idle_%0d", t), {o_busy, o_rsp_valid, o_req_ready}, 3'b001);
        end
        mul_en = 1'b1;

        // Backpressure: response held for 10 cycles while a request waits.
        send(32'h8000_0000, 32'd3, 5'd11);
        i_req_valid = 1'b1;
        i_op_a      = 32'd0;
        i_op_b      = 32'd0;
        i_rd        = 5'd1;
        for (int k = 0; k < 10; k++) begin
            check($sformatf("bp_hold_%0d", k),
                  {o_rsp_valid, o_req_ready, o_rsp_err, o_busy, o_rsp_rd, o_rsp_data},
                  {1'b1, 1'b0, 1'b0, 1'b1, 5'd11, 32'h8000_0000});
            @(negedge i_clk);
        end
        i_req_valid = 1'b0;
        release_rsp();
        repeat (2) @(negedge i_clk);

        // Reset during WAIT; the multiplier answers after reset is released.
        mul_lat = 6;
        send(32'd7, 32'hFFFF_FFFA, 5'd9);
        repeat (2) @(negedge i_clk);
        check("pre_reset_busy", {o_busy, o_mul_valid, o_rsp_valid}, 3'b100);
        i_rst = 1'b1;
        #1;
        check_reset_outs("mid_reset");
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge i_clk);
            check($sformatf("late_ignored_%0d", k), {o_rsp_valid, o_busy, o_mul_valid}, 3'b000);
        end
        check_reset_outs("post_reset");

        // Still functional afterwards.
        mul_lat = 2;
        send(32'hFFFF_FFFD, 32'd5, 5'd21);
        wait_rsp(200, cyc);
        check("after_reset_data", {o_rsp_err, o_rsp_rd, o_rsp_data}, {1'b0, 5'd21, 32'hFFFF_FFF1});
        release_rsp();
        repeat (3) @(negedge i_clk);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mul_issue.md
MUL_ISSUE -- requirements
Module: mul_issue

Interface
REQ-001 SHALL have parameter MUL_TIMEOUT, default 63, meaning the maximum number of WAIT cycles before an error response.
REQ-002 SHALL use one clock and an asynchronous, active-high reset: i_clk input 1 is the clock, rising edge; i_rst input 1 is the asynchronous active-high reset.
REQ-003 SHALL have i_req_valid input 1: request strobe from the execute stage.
REQ-004 SHALL have o_req_ready output 1: request accepted this cycle when high together with i_req_valid.
REQ-005 SHALL have i_op_a and i_op_b, each input 32: two's-complement operands.
REQ-006 SHALL have i_rd input 5: destination register tag.
REQ-007 SHALL have o_mul_valid output 1: one-cycle launch pulse to the multiplier.
REQ-008 SHALL have o_mul_a and o_mul_b, each output 32: sign-magnitude operands to the multiplier (bit 31 sign, bits 30:0 magnitude).
REQ-009 SHALL have i_mul_valid input 1 and i_mul_result input 32: multiplier completion and sign-magnitude product.
REQ-010 SHALL have o_rsp_valid output 1, i_rsp_ready input 1, o_rsp_data output 32 (two's complement), o_rsp_rd output 5 and o_rsp_err output 1: the writeback handshake.
REQ-011 SHALL have o_busy output 1: high in any state other than IDLE.

Function
REQ-012 SHALL implement states IDLE, LAUNCH, WAIT and RESP.
REQ-013 SHALL drive o_req_ready high only in IDLE; on acceptance it SHALL register the operands, the rd tag and the two operand signs.
REQ-014 SHALL convert each operand to sign-magnitude as follows: sign = bit 31; magnitude = low 31 bits of |x|.
REQ-015 Fast path: if either operand is 0, SHALL go IDLE->RESP with data 0, without pulsing o_mul_valid.
REQ-016 Fast path: if either operand is 0x80000000 and the other is nonzero, SHALL go IDLE->RESP with data 0x80000000 when the other operand is odd, else 0.
REQ-017 Otherwise SHALL go IDLE->LAUNCH, assert o_mul_valid for exactly one cycle in LAUNCH, then go to WAIT.
REQ-018 SHALL hold o_mul_a and o_mul_b stable from LAUNCH until leaving WAIT, because the multiplier samples its operands throughout its computation.
REQ-019 In WAIT, on i_mul_valid, SHALL capture the result, convert it as follows and go to RESP: bit31 ? -{1'b0,r[30:0]} : {1'b0,r[30:0]}.
REQ-020 The returned data SHALL equal a*b exactly when |a*b| < 2^31; larger products are returned modulo the multiplier's 31-bit magnitude (documented limitation).
REQ-021 SHALL count WAIT cycles; if the count reaches MUL_TIMEOUT without i_mul_valid, SHALL go to RESP with o_rsp_err=1 and data 0.
REQ-022 If i_mul_valid arrives in the same cycle the count reaches MUL_TIMEOUT, SHALL treat it as a success (o_rsp_err=0).
REQ-023 In RESP, o_rsp_valid SHALL be high and o_rsp_data, o_rsp_rd and o_rsp_err SHALL be stable until i_rsp_ready; on i_rsp_ready SHALL go to IDLE.
REQ-024 SHALL NOT accept a new request in the RESP cycle: there is one outstanding operation at most.
REQ-025 SHALL ignore i_mul_valid outside WAIT.
REQ-026 Fast-path latency SHALL be acceptance to o_rsp_valid = 1 cycle; normal latency SHALL be multiplier latency + 2 cycles.

Reset
REQ-027 While i_rst is high, SHALL be in state IDLE with o_req_ready=1, o_mul_valid=0, o_mul_a=0, o_mul_b=0, o_rsp_valid=0, o_rsp_data=0, o_rsp_rd=0, o_rsp_err=0, o_busy=0, and the timeout counter at 0.
REQ-028 A reset asserted mid-operation SHALL abandon the operation; a late i_mul_valid after reset SHALL be ignored (per REQ-025).

Structure
REQ-029 The state encoding and the sign-magnitude/two's-complement conversion functions SHALL live in shared package alu_pkg.
REQ-030 SHALL contain a single combinational sub-module sm_conv (two's complement <-> sign-magnitude), instantiated twice for the operands and once for the result.
REQ-031 SHALL register all outputs, with no combinational path from i_rsp_ready to o_req_ready.

Verification
REQ-032 Bench SHALL cover: a=7, b=-6 -> one o_mul_valid pulse, o_mul_b=0x80000006, o_rsp_data=0xFFFFFFD6 (-42), err=0.
REQ-033 Bench SHALL cover: a=0, b=12345 -> no o_mul_valid pulse, o_rsp_valid one cycle after acceptance, data=0.
REQ-034 Bench SHALL cover: a=0x80000000, b=3 -> no launch, data=0x80000000; with b=4 -> data=0.
REQ-035 Bench SHALL cover: multiplier model never returns -> o_rsp_err=1 after 63 WAIT cycles, data=0, block back in IDLE after i_rsp_ready.
REQ-036 Bench SHALL cover: i_rsp_ready held low for 10 cycles in RESP -> outputs stable, o_req_ready=0 throughout.
REQ-037 Bench SHALL cover: i_rst asserted in WAIT, followed by a late i_mul_valid -> all outputs at reset values, no response produced.
